// File: rtl/freq_measure_ctrl_if.sv
// Control/result bundle of the frequency measurement sequencer.
// The master side drives start/abort/signal; the slave side returns status and counts.
interface freq_measure_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             abort;
    logic             signal_rectified;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] ref_cnt;
    logic [CNT_W-1:0] sig_cnt;

    modport master (
        output start, abort, signal_rectified,
        input  busy, done, timeout, ref_cnt, sig_cnt
    );

    modport slave (
        input  start, abort, signal_rectified,
        output busy, done, timeout, ref_cnt, sig_cnt
    );
endinterface

// File: rtl/freq_measure_ctrl.sv
// Equal-precision frequency measurement: gate opens and closes on signal rising edges.
// Define FMC_DEGLITCH_EN to insert a DEGLITCH_LEN-cycle stability filter after the synchronizer.
module freq_measure_ctrl #(
    parameter int CNT_W          = 32,
    parameter int GATE_CYCLES    = 50000000,
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int DEGLITCH_LEN   = 4
) (
    input logic                clk,
    input logic                rst_n,
    freq_measure_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, GATE} state_t;

    state_t           state_q;
    logic             sync1_q, sync2_q, filt_d1_q;
    logic             filt, rise, close, expire;
    logic [CNT_W-1:0] timer_q, ref_i_q, sig_i_q;
    logic [CNT_W-1:0] ref_inc, sig_inc;
    logic [CNT_W-1:0] ref_cnt_q, sig_cnt_q;
    logic             busy_q, done_q, timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            filt_d1_q <= 1'b0;
        end else begin
            sync1_q   <= bus.signal_rectified;
            sync2_q   <= sync1_q;
            filt_d1_q <= filt;
        end
    end

`ifdef FMC_DEGLITCH_EN
    localparam int DG_W = $clog2(DEGLITCH_LEN + 1);
    logic [DG_W-1:0] dg_cnt_q;
    logic            filt_q;

    // Level follows the synchronizer only after DEGLITCH_LEN consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dg_cnt_q <= '0;
            filt_q   <= 1'b0;
        end else if (sync2_q == filt_q) begin
            dg_cnt_q <= '0;
        end else if (dg_cnt_q == DG_W'(DEGLITCH_LEN - 1)) begin
            dg_cnt_q <= '0;
            filt_q   <= sync2_q;
        end else begin
            dg_cnt_q <= dg_cnt_q + 1'b1;
        end
    end
    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    assign rise    = filt & ~filt_d1_q;
    assign ref_inc = ref_i_q + 1'b1;
    assign sig_inc = sig_i_q + 1'b1;
    assign close   = (state_q == GATE) && rise && (ref_inc >= CNT_W'(GATE_CYCLES));
    assign expire  = (timer_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Priority inside a measurement: abort, then close, then timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            ref_i_q   <= '0;
            sig_i_q   <= '0;
            ref_cnt_q <= '0;
            sig_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q   <= ARM;
                        busy_q    <= 1'b1;
                        timeout_q <= 1'b0;
                        timer_q   <= '0;
                    end
                end
                ARM, GATE: begin
                    timer_q <= timer_q + 1'b1;
                    if (bus.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (close) begin
                        ref_cnt_q <= ref_inc;
                        sig_cnt_q <= sig_inc;
                        timeout_q <= 1'b0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (expire) begin
                        ref_cnt_q <= '0;
                        sig_cnt_q <= '0;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (state_q == ARM) begin
                        if (rise) begin
                            state_q <= GATE;
                            ref_i_q <= '0;
                            sig_i_q <= '0;
                        end
                    end else begin
                        ref_i_q <= ref_inc;
                        if (rise) sig_i_q <= sig_inc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;
    assign bus.ref_cnt = ref_cnt_q;
    assign bus.sig_cnt = sig_cnt_q;
endmodule

// File: tb/tb_freq_measure_ctrl.sv
// Self-checking bench for freq_measure_ctrl with a rising-edge-list reference model.
module tb_freq_measure_ctrl;
    localparam int CNT_W = 32;
    localparam int GATE  = 100;
    localparam int TMO   = 1000;
    localparam int DGL   = 4;
`ifdef FMC_DEGLITCH_EN
    localparam int LAT = 3 + DGL;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    int   w_per, w_hi, w_gap;
    bit   w_glitch;

    freq_measure_ctrl_if #(.CNT_W(CNT_W)) bus ();

    freq_measure_ctrl #(
        .CNT_W(CNT_W), .GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TMO), .DEGLITCH_LEN(DGL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // Pin level n cycles after start acceptance; optional 2-cycle glitch mid-low.
    function automatic logic wave(input int c);
        int ph;
        if (c < w_gap) return 1'b0;
        ph = (c - w_gap) % w_per;
        if (ph < w_hi) return 1'b1;
        if (w_glitch && (ph == w_hi + 4 || ph == w_hi + 5)) return 1'b1;
        return 1'b0;
    endfunction

    // Opening rise = first pin rise; close = first later rise at least GATE cycles on.
    function automatic void model(output bit to, output int eref, output int esig, output int edone);
        int r0;
        int k;
        r0 = -1; k = 0;
        to = 1'b1; eref = 0; esig = 0; edone = TMO;
        for (int c = 1; c < 4000; c++) begin
            if (wave(c) && !wave(c - 1)) begin
                if (r0 < 0) r0 = c;
                else begin
                    k++;
                    if (c - r0 >= GATE) begin
                        if (c + LAT <= TMO) begin
                            to = 1'b0; eref = c - r0; esig = k; edone = c + LAT;
                        end
                        return;
                    end
                end
            end
        end
    endfunction

    task automatic run_meas(input int per, input int hi, input int gap, input bit glitch,
                            input int mid_start, output int n_done,
                            output logic [CNT_W-1:0] r, output logic [CNT_W-1:0] s,
                            output logic to, output bit busy_ok, output bit pulse_ok);
        w_per = per; w_hi = hi; w_gap = gap; w_glitch = glitch;
        n_done = -1; busy_ok = 1'b1; pulse_ok = 1'b1; r = '0; s = '0; to = 1'b0;
        bus.signal_rectified = 1'b0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        bus.signal_rectified = wave(0);
        for (int n = 1; n <= 1500; n++) begin
            @(negedge clk);
            bus.start = (n == mid_start);
            if (bus.done === 1'b1) begin
                n_done = n; r = bus.ref_cnt; s = bus.sig_cnt; to = bus.timeout;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            bus.signal_rectified = wave(n);
        end
        bus.start = 1'b0;
        @(negedge clk);
        if (bus.done !== 1'b0) pulse_ok = 1'b0;
        bus.signal_rectified = 1'b0;
    endtask

    task automatic test_reset;
        nvec++;
        if ({bus.busy, bus.done, bus.timeout} !== 3'b000) begin
            nerr++; $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.timeout});
        end
        nvec++;
        if (bus.ref_cnt !== '0 || bus.sig_cnt !== '0) begin
            nerr++; $display("FAIL reset_counts got ref=%0d sig=%0d want 0/0", bus.ref_cnt, bus.sig_cnt);
        end
    endtask

    task automatic test_fixed(input string name, input int per, input int exp_ref, input int exp_sig);
        int n; logic [CNT_W-1:0] r, s; logic to; bit bok, pok;
        run_meas(per, per / 2, 10, 1'b0, -1, n, r, s, to, bok, pok);
        nvec++;
        if (n < 0) begin nerr++; $display("FAIL %s_done_wait got none want done", name); end
        nvec++;
        if (r !== CNT_W'(exp_ref) || s !== CNT_W'(exp_sig) || to !== 1'b0) begin
            nerr++; $display("FAIL %s_result got ref=%0d sig=%0d to=%b want ref=%0d sig=%0d to=0",
                             name, r, s, to, exp_ref, exp_sig);
        end
        nvec++;
        if (!bok || !pok) begin
            nerr++; $display("FAIL %s_busy_pulse got busy_ok=%0d pulse_ok=%0d want 1/1", name, bok, pok);
        end
    endtask

    task automatic test_random;
        int n, per, hi, gap, eref, esig, edone; logic [CNT_W-1:0] r, s; logic to; bit eto, bok, pok;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                per = $urandom_range(8, 25); hi = $urandom_range(4, per - 4); gap = $urandom_range(8, 20);
            end else begin
                per = $urandom_range(600, 700); hi = 300; gap = $urandom_range(420, 450);
            end
            w_per = per; w_hi = hi; w_gap = gap; w_glitch = 1'b0;
            model(eto, eref, esig, edone);
            run_meas(per, hi, gap, 1'b0, -1, n, r, s, to, bok, pok);
            nvec++;
            if (n !== edone || r !== CNT_W'(eref) || s !== CNT_W'(esig) || to !== eto || !pok) begin
                nerr++;
                $display("FAIL random%0d got n=%0d ref=%0d sig=%0d to=%b pulse=%0d want n=%0d ref=%0d sig=%0d to=%b pulse=1 (per=%0d hi=%0d gap=%0d)",
                         i, n, r, s, to, pok, edone, eref, esig, eto, per, hi, gap);
            end
        end
    endtask

    task automatic test_timeout;
        int n; logic [CNT_W-1:0] r, s; logic to; bit bok, pok;
        run_meas(10, 5, 100000, 1'b0, -1, n, r, s, to, bok, pok);
        nvec++;
        if (n !== TMO || to !== 1'b1 || r !== '0 || s !== '0) begin
            nerr++; $display("FAIL timeout got n=%0d to=%b ref=%0d sig=%0d want n=%0d to=1 ref=0 sig=0",
                             n, to, r, s, TMO);
        end
        nvec++;
        if (bus.timeout !== 1'b1) begin nerr++; $display("FAIL timeout_hold got %b want 1", bus.timeout); end
        bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        nvec++;
        if (bus.timeout !== 1'b0 || bus.busy !== 1'b1) begin
            nerr++; $display("FAIL timeout_clear got to=%b busy=%b want 0/1", bus.timeout, bus.busy);
        end
        bus.abort = 1'b1;
        @(negedge clk); bus.abort = 1'b0;
    endtask

    task automatic test_start_while_busy;
        int n, eref, esig, edone; logic [CNT_W-1:0] r, s; logic to; bit eto, bok, pok;
        w_per = 10; w_hi = 5; w_gap = 10; w_glitch = 1'b0;
        model(eto, eref, esig, edone);
        run_meas(10, 5, 10, 1'b0, 40, n, r, s, to, bok, pok);
        nvec++;
        if (r !== 32'd100 || s !== 32'd10 || !bok) begin
            nerr++; $display("FAIL start_mid_gate got ref=%0d sig=%0d busy_ok=%0d want 100/10/1", r, s, bok);
        end
        run_meas(10, 5, 10, 1'b0, edone - 1, n, r, s, to, bok, pok);
        nvec++;
        if (n !== edone || bus.busy !== 1'b0) begin
            nerr++; $display("FAIL start_at_done got n=%0d busy=%b want n=%0d busy=0", n, bus.busy, edone);
        end
    endtask

    task automatic test_abort;
        bit seen_done = 1'b0;
        @(negedge clk); bus.abort = 1'b1;
        @(negedge clk); bus.abort = 1'b0;
        nvec++;
        if (bus.busy !== 1'b0 || bus.ref_cnt !== 32'd100) begin
            nerr++; $display("FAIL abort_idle got busy=%b ref=%0d want 0/100", bus.busy, bus.ref_cnt);
        end
        w_per = 10; w_hi = 5; w_gap = 10; w_glitch = 1'b0;
        bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.signal_rectified = wave(0);
        for (int n = 1; n <= 10 + LAT + 50; n++) begin
            @(negedge clk);
            bus.start = (n == 30);
            bus.abort = (n == 10 + LAT + 49);
            bus.signal_rectified = wave(n);
        end
        bus.abort = 1'b0;
        nvec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            nerr++; $display("FAIL abort_gate got busy=%b done=%b want 0/0", bus.busy, bus.done);
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk); bus.signal_rectified = wave(n + 70);
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        bus.signal_rectified = 1'b0;
        nvec++;
        if (seen_done || bus.ref_cnt !== 32'd100 || bus.sig_cnt !== 32'd10 || bus.busy !== 1'b0) begin
            nerr++; $display("FAIL abort_hold got done_seen=%0d ref=%0d sig=%0d busy=%b want 0/100/10/0",
                             seen_done, bus.ref_cnt, bus.sig_cnt, bus.busy);
        end
    endtask

    task automatic test_reset_mid;
        w_per = 10; w_hi = 5; w_gap = 10; w_glitch = 1'b0;
        bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.signal_rectified = wave(0);
        for (int n = 1; n <= 10 + LAT + 30; n++) begin
            @(negedge clk); bus.signal_rectified = wave(n);
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({bus.busy, bus.done, bus.timeout} !== 3'b000 || bus.ref_cnt !== '0 || bus.sig_cnt !== '0) begin
            nerr++; $display("FAIL reset_mid got busy=%b done=%b to=%b ref=%0d sig=%0d want all 0",
                             bus.busy, bus.done, bus.timeout, bus.ref_cnt, bus.sig_cnt);
        end
        bus.signal_rectified = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        test_fixed("after_reset", 10, 100, 10);
    endtask

    task automatic test_glitch;
        int n; logic [CNT_W-1:0] r, s; logic to; bit bok, pok;
        run_meas(20, 10, 10, 1'b1, -1, n, r, s, to, bok, pok);
        nvec++;
`ifdef FMC_DEGLITCH_EN
        if (r !== 32'd100 || s !== 32'd5) begin
            nerr++; $display("FAIL glitch_filtered got ref=%0d sig=%0d want 100/5", r, s);
        end
`else
        if (r !== 32'd100 || s <= 32'd5) begin
            nerr++; $display("FAIL glitch_unfiltered got ref=%0d sig=%0d want ref=100 sig>5", r, s);
        end
`endif
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.signal_rectified = 1'b0;
        w_per = 10; w_hi = 5; w_gap = 10; w_glitch = 1'b0;
        #23;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        test_fixed("normal_p10", 10, 100, 10);
        test_fixed("nonint_p7", 7, 105, 15);
        test_random();
        test_timeout();
        test_fixed("normal_again", 10, 100, 10);
        test_start_while_busy();
        test_abort();
        test_reset_mid();
        test_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
